// File: rtl/cp0_coprocessor.sv
// MIPS coprocessor 0: Count/Compare timer, Status, Cause, EPC, exception entry/ERET and MTC0/MFC0 access.
// Latency: register updates land on the next rising edge; mfc0_data, epc_out and cp0_intr are combinational from registered state.
// Backpressure: stall=1 holds entry/ERET/MTC0 commits while Count, timer pending and interrupt lines keep updating.
module cp0_coprocessor #(
  parameter int COUNT_DIV   = 1,
  parameter bit HW_INT_SYNC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        cu_cp0_w_en,
  input  logic [4:0]  cu_exec_code,
  input  logic [31:0] cu_epc,
  input  logic        exmem_eret,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  input  logic [4:0]  hw_int,
  output logic        cp0_intr,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [1:0] DIV_MAX      = 2'(COUNT_DIV);

  logic [31:0] count_q, compare_q, epc_q;
  logic [31:0] count_nxt;
  logic [1:0]  presc_q, presc_nxt;
  logic        ie_q, exl_q;
  logic [7:0]  im_q;
  logic [4:0]  exc_q;
  logic [1:0]  swip_q;
  logic        pend_q, armed_q;
  logic [4:0]  hw_ip;
  logic [7:0]  ip;
  logic        entry, eret, timer_hit;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // Entry outranks ERET; both and every MTC0 are held off while the pipeline is stalled.
  assign entry      = ~stall & cu_cp0_w_en;
  assign eret       = ~stall & ~cu_cp0_w_en & exmem_eret;
  assign wr_count   = ~stall & mtc0_en & (mtc0_addr == ADDR_COUNT);
  assign wr_compare = ~stall & mtc0_en & (mtc0_addr == ADDR_COMPARE);
  assign wr_status  = ~stall & mtc0_en & (mtc0_addr == ADDR_STATUS);
  assign wr_cause   = ~stall & mtc0_en & (mtc0_addr == ADDR_CAUSE);
  assign wr_epc     = ~stall & mtc0_en & (mtc0_addr == ADDR_EPC);

  generate
    if (HW_INT_SYNC) begin : g_sync
      logic [4:0] sync1_q, sync2_q;
      // Two-flop synchronizer for the asynchronous interrupt lines.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= hw_int;
          sync2_q <= sync1_q;
        end
      end
      assign hw_ip = sync2_q;
    end else begin : g_nosync
      assign hw_ip = hw_int;
    end
  endgenerate

  // Next Count: an MTC0 load overrides the prescaled increment and restarts the prescaler.
  always_comb begin
    presc_nxt = presc_q + 2'd1;
    count_nxt = count_q;
    if (wr_count) begin
      presc_nxt = 2'd0;
      count_nxt = mtc0_data;
    end else if (presc_q == DIV_MAX) begin
      presc_nxt = 2'd0;
      count_nxt = count_q + 32'd1;
    end
  end

  // Pending fires only on a change of Count into the Compare value, never while Count sits there.
  assign timer_hit = armed_q & (count_nxt != count_q) & (count_nxt == compare_q);

  // Timer state: Count, prescaler, Compare, armed flag and pending bit (clear wins over set).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      presc_q   <= '0;
      compare_q <= '0;
      armed_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      count_q <= count_nxt;
      presc_q <= presc_nxt;
      if (wr_compare) begin
        compare_q <= mtc0_data;
        armed_q   <= 1'b1;
        pend_q    <= 1'b0;
      end else if (timer_hit) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Status/Cause/EPC: entry and ERET own EXL/EPC/ExcCode, MTC0 fills in the remaining fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      im_q   <= '0;
      exc_q  <= '0;
      swip_q <= '0;
      epc_q  <= '0;
    end else begin
      if (entry)          exl_q <= 1'b1;
      else if (eret)      exl_q <= 1'b0;
      else if (wr_status) exl_q <= mtc0_data[1];
      if (wr_status) begin
        ie_q <= mtc0_data[0];
        im_q <= mtc0_data[15:8];
      end
      if (wr_cause) swip_q <= mtc0_data[9:8];
      if (entry) begin
        epc_q <= cu_epc;
        exc_q <= cu_exec_code;
      end else if (wr_epc) begin
        epc_q <= mtc0_data;
      end
    end
  end

  assign ip         = {pend_q, hw_ip, swip_q};
  assign status_out = {16'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_out  = {16'd0, ip, 1'b0, exc_q, 2'b00};
  assign epc_out    = epc_q;
  assign cp0_intr   = ie_q & ~exl_q & (|(ip & im_q));

  // MFC0 read mux over the current register values.
  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      ADDR_COUNT:   mfc0_data = count_q;
      ADDR_COMPARE: mfc0_data = compare_q;
      ADDR_STATUS:  mfc0_data = status_out;
      ADDR_CAUSE:   mfc0_data = cause_out;
      ADDR_EPC:     mfc0_data = epc_q;
      default:      mfc0_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_coprocessor.sv
// Self-checking bench for cp0_coprocessor: directed scenarios with literal expectations plus randomized traffic.
// A behavioural model tracks architectural state; a negedge process compares every DUT output against it.
module tb_cp0_coprocessor;
  localparam int COUNT_DIV   = 1;
  localparam bit HW_INT_SYNC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        cu_cp0_w_en = 1'b0;
  logic [4:0]  cu_exec_code = '0;
  logic [31:0] cu_epc = '0;
  logic        exmem_eret = 1'b0;
  logic        mtc0_en = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic [4:0]  mfc0_addr = '0;
  logic [31:0] mfc0_data;
  logic [4:0]  hw_int = '0;
  logic        cp0_intr;
  logic [31:0] epc_out, status_out, cause_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  cp0_coprocessor #(.COUNT_DIV(COUNT_DIV), .HW_INT_SYNC(HW_INT_SYNC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .cu_cp0_w_en(cu_cp0_w_en), .cu_exec_code(cu_exec_code), .cu_epc(cu_epc),
    .exmem_eret(exmem_eret), .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .hw_int(hw_int), .cp0_intr(cp0_intr),
    .epc_out(epc_out), .status_out(status_out), .cause_out(cause_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_base;      // Count value at last load/reset
  int unsigned m_ticks;     // rising edges since that load
  logic [31:0] m_compare, m_epc;
  bit          m_armed, m_pend, m_ie, m_exl;
  logic [7:0]  m_im;
  logic [4:0]  m_exc;
  logic [1:0]  m_swip;
  logic [4:0]  hw_hist [2]; // hw_int as sampled one and two edges ago

  function automatic logic [31:0] m_cnt();
    return m_base + 32'(m_ticks / (COUNT_DIV + 1));
  endfunction

  function automatic logic [7:0] m_ip();
    logic [4:0] hw;
    hw = HW_INT_SYNC ? hw_hist[1] : hw_int;
    return {m_pend, hw, m_swip};
  endfunction

  function automatic logic [31:0] m_status();
    return {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {16'd0, m_ip(), 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic m_intr();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd9:    return m_cnt();
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_base = 0; m_ticks = 0; m_compare = 0; m_epc = 0;
    m_armed = 0; m_pend = 0; m_ie = 0; m_exl = 0; m_im = 0; m_exc = 0; m_swip = 0;
    hw_hist[0] = 0; hw_hist[1] = 0;
  endtask

  // Advance the model by one rising edge using the inputs presented before it.
  task automatic model_step();
    logic [31:0] old_cnt, new_cnt;
    bit commit, ent, ert, mt;
    commit = !stall;
    ent = commit && cu_cp0_w_en;
    ert = commit && !cu_cp0_w_en && exmem_eret;
    mt  = commit && mtc0_en;
    old_cnt = m_cnt();
    if (mt && mtc0_addr == 5'd9) begin
      m_base = mtc0_data; m_ticks = 0;
    end else begin
      m_ticks++;
    end
    new_cnt = m_cnt();
    if (mt && mtc0_addr == 5'd11) begin
      m_compare = mtc0_data; m_armed = 1; m_pend = 0;
    end else if (m_armed && new_cnt != old_cnt && new_cnt == m_compare) begin
      m_pend = 1;
    end
    if (ent) begin
      m_exl = 1; m_epc = cu_epc; m_exc = cu_exec_code;
    end else if (ert) begin
      m_exl = 0;
    end
    if (mt && mtc0_addr == 5'd12) begin
      m_ie = mtc0_data[0]; m_im = mtc0_data[15:8];
      if (!ent && !ert) m_exl = mtc0_data[1];
    end
    if (mt && mtc0_addr == 5'd13) m_swip = mtc0_data[9:8];
    if (mt && mtc0_addr == 5'd14 && !ent) m_epc = mtc0_data;
    hw_hist[1] = hw_hist[0];
    hw_hist[0] = hw_int;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    cu_cp0_w_en = 0; exmem_eret = 0; mtc0_en = 0; stall = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1; mtc0_addr = a; mtc0_data = d;
    cyc();
    mtc0_en = 0;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_mfc0", mfc0_data, m_rd(mfc0_addr));
      chk("mdl_intr", {31'd0, cp0_intr}, {31'd0, m_intr()});
      chk("mdl_epc", epc_out, m_epc);
      chk("mdl_status", status_out, m_status());
      chk("mdl_cause", cause_out, m_cause());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] regs [5];
    bit hit;
    regs[0] = 5'd9; regs[1] = 5'd11; regs[2] = 5'd12; regs[3] = 5'd13; regs[4] = 5'd14;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_en = 1;

    // 1: reset state and Count rate
    for (int i = 0; i < 5; i++) begin
      mfc0_addr = regs[i];
      #1 chk("reset_reg", mfc0_data, 32'd0);
    end
    chk("reset_intr", {31'd0, cp0_intr}, 32'd0);
    mfc0_addr = 5'd9;
    repeat (7) cyc();
    chk("count_rate", mfc0_data, 32'd3);

    // 2: timer pending and its clear
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (cause_out[15]) hit = 1;
      else cyc();
    end
    chk("timer_pend", {31'd0, cause_out[15]}, 32'd1);
    chk("timer_count", mfc0_data, 32'd10);
    chk("timer_intr", {31'd0, cp0_intr}, 32'd1);
    mtc0(5'd11, 32'd50);
    chk("cmp_clear_pend", {31'd0, cause_out[15]}, 32'd0);
    chk("cmp_clear_intr", {31'd0, cp0_intr}, 32'd0);

    // 3: exception entry masks a pending interrupt
    mtc0(5'd11, m_cnt() + 32'd3);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (cause_out[15]) hit = 1;
      else cyc();
    end
    chk("pend_again", {31'd0, cause_out[15]}, 32'd1);
    cu_cp0_w_en = 1; cu_exec_code = 5'd8; cu_epc = 32'h8000_0100;
    cyc();
    cu_cp0_w_en = 0;
    chk("entry_epc", epc_out, 32'h8000_0100);
    chk("entry_exc", {27'd0, cause_out[6:2]}, 32'd8);
    chk("entry_exl", {31'd0, status_out[1]}, 32'd1);
    chk("entry_masked", {31'd0, cp0_intr}, 32'd0);

    // 4: ERET target and re-assertion
    mtc0(5'd14, 32'h0000_0040);
    exmem_eret = 1;
    #1 chk("eret_epc", epc_out, 32'h0000_0040);
    cyc();
    exmem_eret = 0;
    chk("eret_exl", {31'd0, status_out[1]}, 32'd0);
    chk("eret_intr", {31'd0, cp0_intr}, 32'd1);

    // 5: entry and MTC0 Status together, then the same under stall
    cu_cp0_w_en = 1; cu_exec_code = 5'd0; cu_epc = 32'h0000_0200;
    mtc0_en = 1; mtc0_addr = 5'd12; mtc0_data = 32'h0;
    cyc();
    chk("mix_status", status_out, 32'h0000_0002);
    chk("mix_epc", epc_out, 32'h0000_0200);
    stall = 1; cu_exec_code = 5'd8; cu_epc = 32'h0000_1234; mtc0_data = 32'h0000_8001;
    cyc();
    idle_inputs();
    chk("stall_status", status_out, 32'h0000_0002);
    chk("stall_epc", epc_out, 32'h0000_0200);
    chk("stall_exc", {27'd0, cause_out[6:2]}, 32'd0);

    // 6: hardware interrupt through the synchronizer, then async reset
    exmem_eret = 1;
    cyc();
    exmem_eret = 0;
    mtc0(5'd11, 32'hFFFF_0000);
    mtc0(5'd12, 32'h0000_0401);
    chk("hw_pre_intr", {31'd0, cp0_intr}, 32'd0);
    hw_int = 5'b00001;
    cyc();
    chk("hw_sync1", {31'd0, cause_out[10]}, 32'd0);
    cyc();
    chk("hw_sync2", {31'd0, cause_out[10]}, 32'd1);
    chk("hw_intr", {31'd0, cp0_intr}, 32'd1);
    #2 reset = 1;
    model_reset();
    #1;
    chk("rst_cause", cause_out, 32'd0);
    chk("rst_intr", {31'd0, cp0_intr}, 32'd0);
    hw_int = 0;
    @(posedge clk);
    #1 reset = 0;

    // Randomized traffic checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      stall        = ($urandom_range(0, 99) < 20);
      cu_cp0_w_en  = ($urandom_range(0, 99) < 5);
      exmem_eret   = ($urandom_range(0, 99) < 6);
      cu_exec_code = 5'($urandom);
      cu_epc       = $urandom;
      mtc0_en      = ($urandom_range(0, 99) < 30);
      mtc0_addr    = ($urandom_range(0, 5) == 5) ? 5'($urandom) : regs[$urandom_range(0, 4)];
      case (mtc0_addr)
        5'd9:    mtc0_data = m_compare - 32'($urandom_range(0, 4));
        5'd11:   mtc0_data = m_cnt() + 32'($urandom_range(0, 6));
        default: mtc0_data = $urandom;
      endcase
      mfc0_addr = ($urandom_range(0, 5) == 5) ? 5'($urandom) : regs[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) hw_int = 5'($urandom);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
